// File: rtl/tinyvga_demo_pkg.sv
// Shared types and constants for the tinyvga demo sequencer.
package tinyvga_demo_pkg;

  typedef enum logic [1:0] {
    RESET_PROJ = 2'd0,
    FADE_IN    = 2'd1,
    SHOW       = 2'd2,
    FADE_OUT   = 2'd3
  } state_t;

  // Pattern-generator mode per scene; entry [0] is scene 0.
  localparam logic [7:0][3:0] SCENE_MODES = {4'd6, 4'd7, 4'd4, 4'd2,
                                             4'd5, 4'd3, 4'd4, 4'd1};

  localparam int SHOW_FRAMES_DEF = 180;
  localparam int FADE_FRAMES_DEF = 4;
  localparam int RST_CYCLES_DEF  = 16;
  localparam bit VS_ACTIVE_DEF   = 1'b0;

  function automatic logic [3:0] scene_mode(input logic [2:0] s);
    return SCENE_MODES[s];
  endfunction

endpackage

// File: rtl/tinyvga_frame_tick.sv
// Registers vsync and emits a one-cycle pulse after it enters the active level.
module tinyvga_frame_tick #(
  parameter bit VS_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic frame_tick
);

  logic vs_q;

  // History starts at the inactive level so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= ~VS_ACTIVE;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vsync;
      frame_tick <= (vsync == VS_ACTIVE) && (vs_q != VS_ACTIVE);
    end
  end

endmodule

// File: rtl/tinyvga_demo_sequencer.sv
// Scene sequencer: reset the pattern generator, fade depth up, hold, fade down,
// step to the next scene. A manual override freezes the sequence.
module tinyvga_demo_sequencer
  import tinyvga_demo_pkg::*;
#(
  parameter int SHOW_FRAMES = SHOW_FRAMES_DEF,
  parameter int FADE_FRAMES = FADE_FRAMES_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF,
  parameter bit VS_ACTIVE   = VS_ACTIVE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       manual_en,
  input  logic [3:0] manual_mode,
  input  logic [2:0] manual_depth,
  input  logic       advance,
  input  logic       hold,
  output logic [3:0] mode,
  output logic [2:0] depth,
  output logic       proj_rst_n,
  output logic [2:0] scene,
  output logic       fading
);

  localparam int FMAX = (SHOW_FRAMES > FADE_FRAMES) ? SHOW_FRAMES : FADE_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int CW   = $clog2(RST_CYCLES + 1);

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [CW-1:0] cyc_cnt;
  logic          manual_q;
  logic          frame_tick;
  logic          tick;

  tinyvga_frame_tick #(.VS_ACTIVE(VS_ACTIVE)) u_frame_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  // Ticks arriving under manual override are dropped, not deferred.
  assign tick   = frame_tick & ~manual_en;
  assign fading = ~manual_en & ((state == FADE_IN) || (state == FADE_OUT));

  // Sequencer FSM with registered outputs; manual override takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RESET_PROJ;
      scene      <= 3'd0;
      depth      <= 3'd0;
      mode       <= scene_mode(3'd0);
      proj_rst_n <= 1'b0;
      frame_cnt  <= '0;
      cyc_cnt    <= '0;
      manual_q   <= 1'b0;
    end else begin
      manual_q <= manual_en;
      if (manual_en) begin
        mode       <= manual_mode;
        depth      <= manual_depth;
        proj_rst_n <= 1'b1;
      end else if (manual_q) begin
        // Leaving manual: restart the current scene from a clean reset.
        state      <= RESET_PROJ;
        frame_cnt  <= '0;
        cyc_cnt    <= '0;
        depth      <= 3'd0;
        proj_rst_n <= 1'b0;
        mode       <= scene_mode(scene);
      end else begin
        case (state)
          RESET_PROJ: begin
            if (cyc_cnt == CW'(RST_CYCLES - 1)) begin
              state      <= FADE_IN;
              cyc_cnt    <= '0;
              frame_cnt  <= '0;
              proj_rst_n <= 1'b1;
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
          FADE_IN: begin
            if (tick) begin
              if (frame_cnt == FW'(FADE_FRAMES - 1)) begin
                frame_cnt <= '0;
                depth     <= depth + 3'd1;
                if (depth == 3'd6) state <= SHOW;
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
          SHOW: begin
            // advance beats a coincident tick and ignores hold.
            if (advance) begin
              state     <= FADE_OUT;
              frame_cnt <= '0;
            end else if (tick && !hold) begin
              if (frame_cnt == FW'(SHOW_FRAMES - 1)) begin
                state     <= FADE_OUT;
                frame_cnt <= '0;
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
          FADE_OUT: begin
            if (tick) begin
              if (frame_cnt == FW'(FADE_FRAMES - 1)) begin
                frame_cnt <= '0;
                depth     <= depth - 3'd1;
                if (depth == 3'd1) begin
                  scene      <= scene + 3'd1;
                  mode       <= scene_mode(scene + 3'd1);
                  state      <= RESET_PROJ;
                  cyc_cnt    <= '0;
                  proj_rst_n <= 1'b0;
                end
              end else begin
                frame_cnt <= frame_cnt + FW'(1);
              end
            end
          end
          default: state <= RESET_PROJ;
        endcase
      end
    end
  end

endmodule
